// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and FSM state type for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned WORD_LEN  = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arbState_e;

endpackage

// File: rtl/arb_watchdog.sv
// Clear/enable cycle counter that flags when TIMEOUT stalled cycles have elapsed.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // The count excludes the current cycle, so hit asserts in the TIMEOUT-th
  // stalled cycle (count == TIMEOUT-1) rather than one cycle later.
  assign hit = (cnt == CW'(TIMEOUT - 1));

  // Count enabled cycles; clear restarts the window, hold once hit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and load/store (D) ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_SIZE,
  parameter int unsigned DATA_W     = WORD_LEN,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arbState_e           state, nextState;
  logic [SW-1:0]       starveCnt;
  logic [ADDR_W-1:0]   addrReg;
  logic                weReg;
  logic [DATA_W-1:0]   wdataReg;
  logic [DATA_W/8-1:0] wstrbReg;
  logic                grantI, grantD;
  logic                busy, wdHit, starved;

  assign busy    = (state != ARB_IDLE);
  assign starved = i_req && (starveCnt == SW'(STARVE_MAX));

  arb_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy && !mem_ready),
    .hit    (wdHit)
  );

  // Memory side is driven straight from the latched request.
  assign mem_valid = busy;
  assign mem_we    = weReg;
  assign mem_addr  = addrReg;
  assign mem_wdata = wdataReg;
  assign mem_wstrb = wstrbReg;

  // State register, winner payload latch and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      starveCnt <= '0;
      addrReg   <= '0;
      weReg     <= 1'b0;
      wdataReg  <= '0;
      wstrbReg  <= '0;
    end else begin
      state <= nextState;
      if (grantD) begin
        addrReg  <= d_addr;
        weReg    <= d_we;
        wdataReg <= d_wdata;
        wstrbReg <= d_wstrb;
        if (i_req && (starveCnt != SW'(STARVE_MAX))) begin
          starveCnt <= starveCnt + 1'b1;
        end
      end else if (grantI) begin
        addrReg   <= i_addr;
        weReg     <= 1'b0;
        wdataReg  <= '0;
        wstrbReg  <= '1;
        starveCnt <= '0;
      end
    end
  end

  // Arbitration, completion/timeout responses and next-state selection.
  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    i_ready   = 1'b0;
    i_err     = 1'b0;
    i_rdata   = '0;
    d_ready   = 1'b0;
    d_err     = 1'b0;
    d_rdata   = '0;
    unique case (state)
      ARB_IDLE: begin
        if (d_req && !starved) begin
          grantD    = 1'b1;
          nextState = ARB_BUSY_D;
        end else if (i_req) begin
          grantI    = 1'b1;
          nextState = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I: begin
        if (mem_ready) begin
          i_ready   = 1'b1;
          i_rdata   = mem_rdata;
          nextState = ARB_IDLE;
        end else if (wdHit) begin
          i_ready   = 1'b1;
          i_err     = 1'b1;
          nextState = ARB_IDLE;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ready) begin
          d_ready   = 1'b1;
          d_rdata   = weReg ? '0 : mem_rdata;
          nextState = ARB_IDLE;
        end else if (wdHit) begin
          d_ready   = 1'b1;
          d_err     = 1'b1;
          nextState = ARB_IDLE;
        end
      end
      default: nextState = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready, d_err;
  logic [31:0] d_rdata;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int unsigned nCompared   = 0;
  int unsigned nMismatched = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_err     (i_err),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_ready   (d_ready),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 2ns after the next rising edge; inputs change here, checks follow #1.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checkVal("rstMemValid", 32'(mem_valid), 0);
    checkVal("rstIReady",   32'(i_ready), 0);
    checkVal("rstDReady",   32'(d_ready), 0);
    checkVal("rstErr",      32'({i_err, d_err}), 0);
    checkVal("rstMemAddr",  mem_addr, 0);

    // Single load, memory answers 2 cycles after mem_valid.
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wstrb = 4'hF;
    cyc(); #1;
    checkVal("ldValid", 32'(mem_valid), 1);
    checkVal("ldAddr",  mem_addr, 32'h100);
    checkVal("ldWe",    32'(mem_we), 0);
    checkVal("ldEarly", 32'(d_ready), 0);
    cyc(); #1;
    checkVal("ldWait",  32'(d_ready), 0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checkVal("ldReady", 32'(d_ready), 1);
    checkVal("ldData",  d_rdata, 32'hDEADBEEF);
    checkVal("ldErr",   32'(d_err), 0);
    checkVal("ldIQuiet", 32'(i_ready), 0);
    cyc();
    d_req = 1'b0; mem_ready = 1'b0;
    #1;
    checkVal("ldIdle",  32'(mem_valid), 0);
    checkVal("ldPulse", 32'(d_ready), 0);
    checkVal("ldRdata0", d_rdata, 0);

    // Simultaneous fetch and store: store first, then fetch.
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    cyc(); #1;
    checkVal("simWe",    32'(mem_we), 1);
    checkVal("simAddr",  mem_addr, 32'h200);
    checkVal("simWdata", mem_wdata, 32'h12345678);
    checkVal("simWstrb", 32'(mem_wstrb), 32'hF);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
    #1;
    checkVal("simDReady", 32'(d_ready), 1);
    checkVal("simStData", d_rdata, 0);
    checkVal("simINot",   32'(i_ready), 0);
    cyc();
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    #1;
    checkVal("simGap",   32'(mem_valid), 0);
    checkVal("simGapI",  32'(i_ready), 0);
    cyc(); #1;
    checkVal("simIAddr",  mem_addr, 32'h0);
    checkVal("simIWe",    32'(mem_we), 0);
    checkVal("simIWstrb", 32'(mem_wstrb), 32'hF);
    mem_ready = 1'b1; mem_rdata = 32'h00000013;
    #1;
    checkVal("simIReady", 32'(i_ready), 1);
    checkVal("simIData",  i_rdata, 32'h13);
    checkVal("simDNot",   32'(d_ready), 0);
    cyc();
    i_req = 1'b0; mem_ready = 1'b0;

    // Starvation: I held, D streams loads; I wins after 4 D grants.
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      checkVal($sformatf("stvD%0dAddr", k), mem_addr, 32'h300 + 32'(4 * k));
      mem_ready = 1'b1; mem_rdata = 32'(k + 1);
      #1;
      checkVal($sformatf("stvD%0dData", k), d_rdata, 32'(k + 1));
      checkVal($sformatf("stvD%0dINot", k), 32'(i_ready), 0);
      cyc();
      mem_ready = 1'b0; d_addr = d_addr + 32'd4;
    end
    cyc(); #1;
    checkVal("stvIAddr", mem_addr, 32'h40);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0040;
    #1;
    checkVal("stvIReady", 32'(i_ready), 1);
    checkVal("stvDNot",   32'(d_ready), 0);
    cyc();
    mem_ready = 1'b0; i_addr = 32'h44;
    // Counter cleared by the I grant, so D wins again despite I waiting.
    for (int k = 4; k < 6; k++) begin
      cyc(); #1;
      checkVal($sformatf("stvD%0dAddr", k), mem_addr, 32'h300 + 32'(4 * k));
      mem_ready = 1'b1; mem_rdata = 32'(k + 1);
      #1;
      checkVal($sformatf("stvD%0dReady", k), 32'(d_ready), 1);
      cyc();
      mem_ready = 1'b0; d_addr = d_addr + 32'd4;
    end
    d_req = 1'b0;
    cyc(); #1;
    checkVal("stvI2Addr", mem_addr, 32'h44);
    mem_ready = 1'b1;
    #1;
    checkVal("stvI2Ready", 32'(i_ready), 1);
    cyc();
    i_req = 1'b0; mem_ready = 1'b0;

    // Timeout on a fetch: error pulse in the 8th BUSY cycle.
    i_req = 1'b1; i_addr = 32'h80; mem_rdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 7; c++) begin
      cyc(); #1;
      checkVal($sformatf("toWait%0d", c), 32'({mem_valid, i_ready}), 32'b10);
    end
    cyc(); #1;
    checkVal("toReady", 32'(i_ready), 1);
    checkVal("toErr",   32'(i_err), 1);
    checkVal("toRdata", i_rdata, 0);
    checkVal("toValid", 32'(mem_valid), 1);
    cyc();
    i_req = 1'b0; mem_ready = 1'b1;
    #1;
    checkVal("toLateValid", 32'(mem_valid), 0);
    checkVal("toLateReady", 32'({i_ready, d_ready, i_err, d_err}), 0);
    cyc();
    mem_ready = 1'b0;

    // mem_ready coinciding with the watchdog limit is a normal completion.
    i_req = 1'b1; i_addr = 32'h84; mem_rdata = 32'h0BADF00D;
    for (int c = 1; c <= 7; c++) cyc();
    cyc();
    mem_ready = 1'b1;
    #1;
    checkVal("toEdgeReady", 32'(i_ready), 1);
    checkVal("toEdgeErr",   32'(i_err), 0);
    checkVal("toEdgeData",  i_rdata, 32'h0BADF00D);
    cyc();
    i_req = 1'b0; mem_ready = 1'b0;

    // Reset during BUSY_D abandons the load; the re-presented load completes.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    cyc(); #1;
    checkVal("rmBusy", 32'(mem_valid), 1);
    rst = 1'b1;
    #1;
    checkVal("rmNoReady", 32'(d_ready), 0);
    cyc();
    rst = 1'b0;
    #1;
    checkVal("rmValid", 32'(mem_valid), 0);
    checkVal("rmReady", 32'(d_ready), 0);
    cyc(); #1;
    checkVal("rmReAddr", mem_addr, 32'h500);
    mem_ready = 1'b1; mem_rdata = 32'h000055AA;
    #1;
    checkVal("rmReReady", 32'(d_ready), 1);
    checkVal("rmReData",  d_rdata, 32'h55AA);
    cyc();
    d_req = 1'b0; mem_ready = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer/arbiter sharing one single-ported unified memory between the instruction-fetch port (I) and the load/store port (D) of the RV32I core. Holds at most one memory transaction in flight, latches the winner's request, drives the memory handshake, returns the response to the owning requester, and aborts with an error on memory timeout. Sits between the PC/IMem-side fetch logic and the DMem-side access logic. It replaces the separate IMem/DMem instances when the design moves to a single memory.

## Interface
- `ADDR_W`, default 32: address width (`ADDR_SIZE`).
- `DATA_W`, default 32: data width (`WORD_LEN`).
- `STARVE_MAX`, default 4: consecutive D grants allowed while I waits.
- `TIMEOUT`, default 255: cycles in BUSY without `mem_ready` before abort.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request, held until `i_ready`.
- `i_addr` in ADDR_W: fetch address, stable while `i_req`.
- `i_ready` out 1: one-cycle completion pulse for I.
- `i_err` out 1: with `i_ready`, transaction aborted by timeout.
- `i_rdata` out DATA_W: fetch data, valid with `i_ready`.
- `d_req` in 1: data request, held until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_wstrb` in DATA_W/8: byte enables.
- `d_ready` out 1: completion pulse for D.
- `d_err` out 1: D timeout abort.
- `d_rdata` out DATA_W: load data, valid with `d_ready`.
- `mem_valid` out 1: request to memory, held until `mem_ready`.
- `mem_we` out 1: write enable.
- `mem_addr` out ADDR_W: address.
- `mem_wdata` out DATA_W: write data.
- `mem_wstrb` out DATA_W/8: byte enables; all-ones for I.
- `mem_ready` in 1: memory accepts and completes in this cycle.
- `mem_rdata` in DATA_W: read data, valid with `mem_ready`.

## Operation
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE behaviour:
  - If any request is pending, pick a winner, latch its addr/we/wdata/wstrb into registers, and go to BUSY_x.
  - An I request latches `we=0` and `wstrb=all-ones`.
- Arbitration:
  - D wins over I, because the older instruction goes first.
  - Exception: I wins when `starve_cnt == STARVE_MAX` and `i_req` is high.
  - `starve_cnt` increments on each D grant made while `i_req` is high, saturating at STARVE_MAX.
  - `starve_cnt` clears on every I grant.
- BUSY_x behaviour:
  - `mem_valid`=1 and `mem_*` driven from the latched registers.
  - On `mem_ready`:
    - `x_ready`=1 combinationally in that cycle.
    - `x_rdata` = `mem_rdata` for loads and fetches, 0 for stores.
    - Next state is IDLE.
- Watchdog:
  - `wd_cnt` clears on entry to BUSY and increments each BUSY cycle without `mem_ready`.
  - When it reaches TIMEOUT:
    - `x_ready`=1, `x_err`=1, `x_rdata`=0 in that cycle.
    - `mem_valid` still 1 in that cycle; go to IDLE.
  - Any late `mem_ready` seen in IDLE is ignored.
- Requester rules:
  - Keep `req` and its payload stable until `ready`.
  - Deassert `req`, or present a new request, in the cycle after `ready`.
- Protocol violations:
  - If `req` drops while BUSY, the transaction still completes and `ready` still pulses.
  - Payload changes while BUSY are not seen, because the payload is latched.
- Outside their pulse, `i_rdata` and `d_rdata` are 0, and the err and ready outputs are 0.

## Timing
- Reset (rst high at an edge):
  - State goes to IDLE; `starve_cnt`=0, `wd_cnt`=0, `mem_valid`=0, all latched registers=0.
  - All ready and err outputs are 0 from the cycle after.
- Reset mid-transaction: the transaction is abandoned with no `ready` pulse; `mem_valid` is 0 in the cycle after the reset edge.
- Latency:
  - `req` seen in IDLE at edge N → `mem_valid` in cycle N+1.
  - `ready` in the same cycle as `mem_ready`.
  - Minimum is 1 cycle after the request edge.
- Throughput: the cycle after completion is always IDLE, so back-to-back issue is at most one transaction per (memory latency + 1) cycles.
- Simultaneous `i_req` and `d_req` in IDLE: D is granted unless the starvation rule applies. The loser is granted no earlier than the IDLE cycle after the winner completes.
- `mem_ready` in the same cycle the watchdog hits TIMEOUT: treated as normal completion, `x_err`=0.

## Structure
- Shared constants go in `defines.v`:
  - `ADDR_SIZE` and `WORD_LEN` already live there.
  - Add the state encodings `ARB_IDLE`, `ARB_BUSY_I`, `ARB_BUSY_D` (2 bits).
- One natural sub-module, `arb_watchdog`: a clear/enable counter with a TIMEOUT compare, reusable elsewhere.
- The arbitration pick and `starve_cnt` stay inline.

## Test plan
- Single load:
  - Stimulus: `d_req`, `d_addr`=0x100, memory returns 0xDEADBEEF with `mem_ready` 2 cycles after `mem_valid`.
  - Required: `d_ready` pulses once with `d_rdata`=0xDEADBEEF; I is untouched.
- Simultaneous requests:
  - Stimulus: I at 0x0, D store at 0x200 with wdata 0x12345678 and wstrb 0xF.
  - Required: store issues first (`mem_we`=1), then fetch. `d_ready` precedes `i_ready` by at least 2 cycles.
- Starvation:
  - Stimulus: `i_req` held while D issues 6 back-to-back requests, STARVE_MAX=4.
  - Required: I is granted after exactly 4 D grants; `starve_cnt` is then 0.
- Timeout:
  - Stimulus: TIMEOUT=8, memory never asserts `mem_ready` on an I request.
  - Required: `i_ready`=`i_err`=1 and `i_rdata`=0 exactly 8 BUSY cycles after entry. A `mem_ready` in the following IDLE cycle produces no pulse.
- Reset mid-transaction:
  - Stimulus: rst during BUSY_D.
  - Required: `mem_valid`=0 the next cycle, no `d_ready`. A request re-presented after reset completes normally.
